// File: rtl/pwm_softstart_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_softstart_ctrl_if
//  Description : Control/status bundle between a sequencer user (master) and
//                the pwm soft-start sequencer (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface pwm_softstart_ctrl_if #(
  parameter int SEL_W = 2,
  parameter int CNT_W = 8
);
  logic             start;
  logic             stop;
  logic [SEL_W-1:0] target;
  logic [CNT_W-1:0] hold;
  logic             period_end;
  logic [SEL_W-1:0] select;
  logic             pwm_en;
  logic [1:0]       state;
  logic             done;

  modport master (
    output start, stop, target, hold, period_end,
    input  select, pwm_en, state, done
  );

  modport slave (
    input  start, stop, target, hold, period_end,
    output select, pwm_en, state, done
  );
endinterface
`default_nettype wire

// File: rtl/pwm_softstart_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_softstart_ctrl
//  Description : Soft-start / soft-stop sequencer for the pwm SELECT input.
//                Ramps the duty level up to a latched target and back down
//                to zero, changing it only on pwm period boundaries.
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_softstart_ctrl #(
  parameter int SEL_W = 2,
  parameter int CNT_W = 8
) (
  input  wire                   clk_i,
  input  wire                   rst_i,
  pwm_softstart_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_RAMP_UP   = 2'b01,
    S_RUN       = 2'b10,
    S_RAMP_DOWN = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic             en_q,    en_d;
  logic             done_q,  done_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [SEL_W-1:0] tgt_q,   tgt_d;
  logic [CNT_W-1:0] hold_q,  hold_d;

  logic             w_step;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [SEL_W-1:0] w_sel_inc;
  logic [SEL_W-1:0] w_sel_dec;

  // hold_q is never 0, so hold_q-1 cannot underflow
  assign w_step    = bus.period_end && (cnt_q == (hold_q - CNT_W'(1)));
  assign w_cnt_inc = cnt_q + CNT_W'(1);
  assign w_sel_inc = sel_q + SEL_W'(1);
  assign w_sel_dec = sel_q - SEL_W'(1);

  // Next-state and output decode; every target defaults to its held value
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    en_d    = en_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    hold_d  = hold_q;

    case (state_q)
      S_IDLE: begin
        // STOP wins over a coincident START; PERIOD_END is ignored here
        if (bus.start && !bus.stop) begin
          tgt_d   = bus.target;
          hold_d  = (bus.hold == '0) ? CNT_W'(1) : bus.hold;
          cnt_d   = '0;
          en_d    = 1'b1;
          state_d = (bus.target == '0) ? S_RUN : S_RAMP_UP;
        end
      end

      S_RAMP_UP: begin
        // STOP takes precedence over a step boundary on the same edge
        if (bus.stop) begin
          state_d = S_RAMP_DOWN;
          cnt_d   = '0;
        end else if (w_step) begin
          cnt_d = '0;
          sel_d = w_sel_inc;
          if (w_sel_inc == tgt_q) begin
            state_d = S_RUN;
          end
        end else if (bus.period_end) begin
          cnt_d = w_cnt_inc;
        end
      end

      S_RUN: begin
        if (bus.stop) begin
          state_d = S_RAMP_DOWN;
          cnt_d   = '0;
        end else if (w_step) begin
          cnt_d = '0;
        end else if (bus.period_end) begin
          cnt_d = w_cnt_inc;
        end
      end

      S_RAMP_DOWN: begin
        // A full hold interval at level 0 runs before the pwm is disabled
        if (w_step) begin
          cnt_d = '0;
          if (sel_q != '0) begin
            sel_d = w_sel_dec;
          end else begin
            en_d    = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (bus.period_end) begin
          cnt_d = w_cnt_inc;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      hold_q  <= CNT_W'(1);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.select = sel_q;
  assign bus.pwm_en = en_q;
  assign bus.state  = state_q;
  assign bus.done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_softstart_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_softstart_ctrl
//  Description : Self-checking bench for pwm_softstart_ctrl using an
//                expected-result queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pwm_softstart_ctrl;

  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_UP   = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;
  localparam logic [1:0] ST_DOWN = 2'b11;

  logic clk;
  logic rst;

  pwm_softstart_ctrl_if #(.SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

  pwm_softstart_ctrl #(.SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    string      tag;
    logic [1:0] sel;
    logic       en;
    logic [1:0] st;
    logic       done;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;

  // What the bench believes the outputs currently are
  logic [1:0] cur_sel;
  logic       cur_en;
  logic [1:0] cur_st;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then
  // pop and compare once the DUT has registered them.
  task automatic cyc(input logic st, input logic sp, input logic pe, input logic r,
                     input logic [1:0] es, input logic ee, input logic [1:0] est,
                     input logic ed, input string tag);
    exp_t e;
    bus.start      = st;
    bus.stop       = sp;
    bus.period_end = pe;
    rst            = r;
    sb.push_back('{tag, es, ee, est, ed});
    cur_sel = es;
    cur_en  = ee;
    cur_st  = est;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_val({e.tag, ".select"}, 32'(bus.select), 32'(e.sel));
    check_val({e.tag, ".pwm_en"}, 32'(bus.pwm_en), 32'(e.en));
    check_val({e.tag, ".state"},  32'(bus.state),  32'(e.st));
    check_val({e.tag, ".done"},   32'(bus.done),   32'(e.done));
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.period_end = 1'b0;
  endtask

  task automatic quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, cur_sel, cur_en, cur_st, 1'b0, tag);
    end
  endtask

  // Nine quiet cycles then a PERIOD_END strobe, i.e. a 10-clock pwm period
  task automatic period(input logic [1:0] es, input logic ee, input logic [1:0] est,
                        input logic ed, input string tag);
    quiet(9, {tag, ".gap"});
    cyc(1'b0, 1'b0, 1'b1, 1'b0, es, ee, est, ed, tag);
  endtask

  task automatic pe(input logic [1:0] es, input logic ee, input logic [1:0] est,
                    input logic ed, input string tag);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, es, ee, est, ed, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.period_end = 1'b0;
    bus.target     = '0;
    bus.hold       = '0;

    // 1: reset dominates toggling START/STOP
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, ST_IDLE, 1'b0, "rst1");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, ST_IDLE, 1'b0, "rst2");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, ST_IDLE, 1'b0, "rst3");
    quiet(2, "idle");
    pe(2'd0, 1'b0, ST_IDLE, 1'b0, "idle_pe");

    // 2: ramp-up TARGET=3 HOLD=2; HOLD change after start must not matter
    bus.target = 2'd3;
    bus.hold   = 8'd2;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, ST_UP, 1'b0, "up_start");
    bus.hold   = 8'd1;
    bus.target = 2'd1;
    period(2'd0, 1'b1, ST_UP,  1'b0, "up_pe1");
    period(2'd1, 1'b1, ST_UP,  1'b0, "up_pe2");
    period(2'd1, 1'b1, ST_UP,  1'b0, "up_pe3");
    period(2'd2, 1'b1, ST_UP,  1'b0, "up_pe4");
    period(2'd2, 1'b1, ST_UP,  1'b0, "up_pe5");
    period(2'd3, 1'b1, ST_RUN, 1'b0, "up_pe6");
    // RUN: START ignored, TARGET change ignored, PERIOD_END keeps level
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, ST_RUN, 1'b0, "run_start");
    bus.target = 2'd0;
    pe(2'd3, 1'b1, ST_RUN, 1'b0, "run_pe1");
    pe(2'd3, 1'b1, ST_RUN, 1'b0, "run_pe2");
    // ramp-down with hold 2: two strobes per level, START ignored
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, ST_DOWN, 1'b0, "h2_stop");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, ST_DOWN, 1'b0, "h2_start_ign");
    pe(2'd3, 1'b1, ST_DOWN, 1'b0, "h2_pe1");
    pe(2'd2, 1'b1, ST_DOWN, 1'b0, "h2_pe2");
    pe(2'd2, 1'b1, ST_DOWN, 1'b0, "h2_pe3");
    pe(2'd1, 1'b1, ST_DOWN, 1'b0, "h2_pe4");
    pe(2'd1, 1'b1, ST_DOWN, 1'b0, "h2_pe5");
    pe(2'd0, 1'b1, ST_DOWN, 1'b0, "h2_pe6");
    pe(2'd0, 1'b1, ST_DOWN, 1'b0, "h2_pe7");
    pe(2'd0, 1'b0, ST_IDLE, 1'b1, "h2_done");
    quiet(1, "h2_after");

    // 3: ramp-down from RUN with HOLD=1
    bus.target = 2'd3;
    bus.hold   = 8'd1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, ST_UP, 1'b0, "h1_start");
    pe(2'd1, 1'b1, ST_UP,  1'b0, "h1_up1");
    pe(2'd2, 1'b1, ST_UP,  1'b0, "h1_up2");
    pe(2'd3, 1'b1, ST_RUN, 1'b0, "h1_up3");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, ST_DOWN, 1'b0, "h1_stop");
    period(2'd2, 1'b1, ST_DOWN, 1'b0, "h1_dn1");
    period(2'd1, 1'b1, ST_DOWN, 1'b0, "h1_dn2");
    period(2'd0, 1'b1, ST_DOWN, 1'b0, "h1_dn3");
    period(2'd0, 1'b0, ST_IDLE, 1'b1, "h1_done");
    quiet(2, "h1_after");

    // 4: abort mid ramp, STOP coincident with a step boundary
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, ST_UP, 1'b0, "ab_start");
    pe(2'd1, 1'b1, ST_UP, 1'b0, "ab_up1");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, ST_DOWN, 1'b0, "ab_stop_pe");
    period(2'd0, 1'b1, ST_DOWN, 1'b0, "ab_dn1");
    period(2'd0, 1'b0, ST_IDLE, 1'b1, "ab_done");
    quiet(1, "ab_after");

    // 5a: HOLD=0 behaves as 1
    bus.target = 2'd2;
    bus.hold   = 8'd0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, ST_UP, 1'b0, "h0_start");
    pe(2'd1, 1'b1, ST_UP,  1'b0, "h0_up1");
    pe(2'd2, 1'b1, ST_RUN, 1'b0, "h0_up2");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, ST_DOWN, 1'b0, "h0_stop");
    pe(2'd1, 1'b1, ST_DOWN, 1'b0, "h0_dn1");
    pe(2'd0, 1'b1, ST_DOWN, 1'b0, "h0_dn2");
    pe(2'd0, 1'b0, ST_IDLE, 1'b1, "h0_done");

    // 5b: START+STOP in IDLE stays IDLE
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, ST_IDLE, 1'b0, "ss_idle");
    quiet(2, "ss_after");

    // 5c: TARGET=0 goes straight to RUN at level 0
    bus.target = 2'd0;
    bus.hold   = 8'd1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, ST_RUN, 1'b0, "t0_start");
    pe(2'd0, 1'b1, ST_RUN, 1'b0, "t0_pe");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, ST_DOWN, 1'b0, "t0_stop");
    pe(2'd0, 1'b0, ST_IDLE, 1'b1, "t0_done");

    // 6: reset mid ramp-up at SELECT=2
    bus.target = 2'd3;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, ST_UP, 1'b0, "mr_start");
    pe(2'd1, 1'b1, ST_UP, 1'b0, "mr_up1");
    pe(2'd2, 1'b1, ST_UP, 1'b0, "mr_up2");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, ST_IDLE, 1'b0, "mr_rst");
    quiet(2, "mr_after");

    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
